// File: rtl/keypad_number_entry.sv
// Scanned 4x4 keypad reader: debounced key presses build a decimal entry 0..999, latched by '#'.
// Build option: define KEYPAD_BACKSPACE_EN to make '*' a backspace; otherwise '*' clears the entry.
module keypad_number_entry #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] ROW,
    output logic [3:0] COL,
    output logic [9:0] entry,
    output logic [1:0] digits,
    output logic [9:0] number,
    output logic       number_valid,
    output logic       key_event,
    output logic [3:0] key_code,
    output logic [1:0] dbg_state
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [3:0] KEY_STAR  = 4'd12;
    localparam logic [3:0] KEY_ENTER = 4'd14;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS_Q,
        S_HELD,
        S_REL_Q
    } state_t;

    logic [DW-1:0] scan_cnt;
    logic [1:0]    col_idx;
    logic [3:0]    row_meta;
    logic [3:0]    row_sync;
    logic [15:0]   pressed_mask;
    logic [15:0]   mask_next;
    logic          sweep_done;
    logic          dwell_end;

    logic [4:0]    n_set;
    logic [3:0]    single_code;
    logic          is_none;
    logic          is_single;

    state_t        state, state_n;
    logic [3:0]    cand, cand_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          fire;

    logic          is_digit;
    logic [3:0]    digit_val;
    logic [9:0]    entry_x10;

    assign dwell_end = (scan_cnt == DW'(SCAN_DIV - 1));
    assign dbg_state = state;

    // Each column owns four bits of the mask; only the active column's bits are refreshed.
    always_comb begin
        mask_next = pressed_mask;
        for (int r = 0; r < 4; r++) begin
            mask_next[{2'(r), col_idx}] = ~row_sync[r];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt     <= '0;
            col_idx      <= 2'd0;
            COL          <= 4'b1110;
            row_meta     <= 4'hF;
            row_sync     <= 4'hF;
            pressed_mask <= '0;
            sweep_done   <= 1'b0;
        end else begin
            row_meta   <= ROW;
            row_sync   <= row_meta;
            sweep_done <= dwell_end && (col_idx == 2'd3);
            if (dwell_end) begin
                scan_cnt     <= '0;
                col_idx      <= col_idx + 2'd1;
                COL          <= {COL[2:0], COL[3]};
                pressed_mask <= mask_next;
            end else begin
                scan_cnt <= scan_cnt + DW'(1);
            end
        end
    end

    always_comb begin
        n_set       = '0;
        single_code = '0;
        for (int i = 0; i < 16; i++) begin
            if (pressed_mask[i]) begin
                n_set       = n_set + 5'd1;
                single_code = 4'(i);
            end
        end
    end

    assign is_none   = (n_set == 5'd0);
    assign is_single = (n_set == 5'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cand  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cand  <= cand_n;
            cnt   <= cnt_n;
        end
    end

    // MULTI sweeps are neither a key nor a release: they abort qualification but keep a held key held.
    always_comb begin
        state_n = state;
        cand_n  = cand;
        cnt_n   = cnt;
        fire    = 1'b0;
        if (sweep_done) begin
            case (state)
                S_IDLE: begin
                    if (is_single) begin
                        cand_n = single_code;
                        if (DEBOUNCE == 1) begin
                            state_n = S_HELD;
                            fire    = 1'b1;
                        end else begin
                            state_n = S_PRESS_Q;
                            cnt_n   = CW'(1);
                        end
                    end
                end
                S_PRESS_Q: begin
                    if (is_single && (single_code == cand)) begin
                        if (cnt == CW'(DEBOUNCE - 1)) begin
                            state_n = S_HELD;
                            fire    = 1'b1;
                        end else begin
                            cnt_n = cnt + CW'(1);
                        end
                    end else if (is_single) begin
                        cand_n = single_code;
                        cnt_n  = CW'(1);
                    end else begin
                        state_n = S_IDLE;
                    end
                end
                S_HELD: begin
                    if (is_none) begin
                        if (DEBOUNCE == 1) begin
                            state_n = S_IDLE;
                        end else begin
                            state_n = S_REL_Q;
                            cnt_n   = CW'(1);
                        end
                    end
                end
                S_REL_Q: begin
                    if (is_none) begin
                        if (cnt == CW'(DEBOUNCE - 1)) begin
                            state_n = S_IDLE;
                        end else begin
                            cnt_n = cnt + CW'(1);
                        end
                    end else begin
                        state_n = S_HELD;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_comb begin
        is_digit  = 1'b1;
        digit_val = 4'd0;
        case (single_code)
            4'd0:    digit_val = 4'd1;
            4'd1:    digit_val = 4'd2;
            4'd2:    digit_val = 4'd3;
            4'd4:    digit_val = 4'd4;
            4'd5:    digit_val = 4'd5;
            4'd6:    digit_val = 4'd6;
            4'd8:    digit_val = 4'd7;
            4'd9:    digit_val = 4'd8;
            4'd10:   digit_val = 4'd9;
            4'd13:   digit_val = 4'd0;
            default: is_digit  = 1'b0;
        endcase
    end

    // With at most two digits present entry <= 99, so x10 + d stays within 10 bits.
    assign entry_x10 = {entry[6:0], 3'b000} + {entry[8:0], 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry        <= '0;
            digits       <= '0;
            number       <= '0;
            number_valid <= 1'b0;
            key_event    <= 1'b0;
            key_code     <= '0;
        end else begin
            key_event    <= fire;
            number_valid <= 1'b0;
            if (fire) begin
                key_code <= single_code;
                if (is_digit) begin
                    if (digits != 2'd3) begin
                        entry  <= entry_x10 + {6'd0, digit_val};
                        digits <= digits + 2'd1;
                    end
                end else if (single_code == KEY_ENTER) begin
                    if (digits != 2'd0) begin
                        number       <= entry;
                        number_valid <= 1'b1;
                        entry        <= '0;
                        digits       <= '0;
                    end
                end else if (single_code == KEY_STAR) begin
`ifdef KEYPAD_BACKSPACE_EN
                    if (digits != 2'd0) begin
                        entry  <= entry / 10'd10;
                        digits <= digits - 2'd1;
                    end
`else
                    entry  <= '0;
                    digits <= '0;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_number_entry.sv
// Bench for keypad_number_entry: a keypad matrix model driven per sweep, checked against a
// sweep-level reference of the press/release rules and the entry arithmetic.
module tb_keypad_number_entry;

    localparam int SD    = 4;
    localparam int DEB   = 3;
    localparam int SWEEP = 4 * SD;

    logic       clk;
    logic       rst_n;
    logic [3:0] ROW;
    logic [3:0] COL;
    logic [9:0] entry;
    logic [1:0] digits;
    logic [9:0] number;
    logic       number_valid;
    logic       key_event;
    logic [3:0] key_code;
    logic [1:0] dbg_state;

    keypad_number_entry #(.SCAN_DIV(SD), .DEBOUNCE(DEB)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ROW(ROW),
        .COL(COL),
        .entry(entry),
        .digits(digits),
        .number(number),
        .number_valid(number_valid),
        .key_event(key_event),
        .key_code(key_code),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- keypad matrix model ----------------
    logic [15:0] pressed;
    always_comb begin
        ROW = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[4 * r + c] && !COL[c]) ROW[r] = 1'b0;
    end

    // ---------------- checking ----------------
    int vectors = 0;
    int errors  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model (one step per sweep) ----------------
    logic [9:0] exp_q[$];
    int  m_entry, m_digits, m_number, m_code;
    bit  m_ev, m_nv, m_latched;
    int  run_key, run_len, none_run;

    function automatic int digit_of(input int code);
        case (code)
            0: return 1;  1: return 2;  2: return 3;
            4: return 4;  5: return 5;  6: return 6;
            8: return 7;  9: return 8; 10: return 9;
            13: return 0;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        m_entry = 0; m_digits = 0; m_number = 0; m_code = 0;
        m_ev = 0; m_nv = 0; m_latched = 0;
        run_key = -1; run_len = 0; none_run = 0;
    endtask

    task automatic model_step(input logic [15:0] m);
        int n, k, d;
        n = $countones(m);
        k = -1;
        for (int i = 0; i < 16; i++) if (m[i]) k = i;
        m_ev = 0;
        m_nv = 0;
        if (!m_latched) begin
            if (n == 1) begin
                if (run_len > 0 && k == run_key) run_len++;
                else begin run_key = k; run_len = 1; end
                if (run_len == DEB) begin m_latched = 1; none_run = 0; m_ev = 1; end
            end else begin
                run_len = 0;
            end
        end else if (n == 0) begin
            none_run++;
            if (none_run == DEB) begin m_latched = 0; run_len = 0; end
        end else begin
            none_run = 0;
        end
        if (m_ev) begin
            m_code = k;
            d = digit_of(k);
            if (d >= 0) begin
                if (m_digits < 3) begin m_entry = m_entry * 10 + d; m_digits++; end
            end else if (k == 14) begin
                if (m_digits > 0) begin
                    m_number = m_entry; m_nv = 1;
                    exp_q.push_back(10'(m_entry));
                    m_entry = 0; m_digits = 0;
                end
            end else if (k == 12) begin
`ifdef KEYPAD_BACKSPACE_EN
                if (m_digits > 0) begin m_entry = m_entry / 10; m_digits--; end
`else
                m_entry = 0; m_digits = 0;
`endif
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    int          t_cnt;
    bit          have_prev;
    logic [15:0] prev_mask;
    int          ev_seen;
    logic [15:0] sweep_q[$];

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_col", COL, 4'b1110);
        check("rst_entry", entry, 0);
        check("rst_digits", digits, 0);
        check("rst_number", number, 0);
        check("rst_nv", number_valid, 0);
        check("rst_kev", key_event, 0);
        check("rst_code", key_code, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        t_cnt = 0;
        have_prev = 0;
        model_reset();
    endtask

    // Presents one mask for a whole sweep; the previous sweep's result lands on the first edge.
    task automatic play_sweep(input logic [15:0] m);
        int  extra;
        logic [3:0] ec;
        extra = 0;
        pressed = m;
        for (int i = 0; i < SWEEP; i++) begin
            @(posedge clk);
            @(negedge clk);
            t_cnt++;
            ec = 4'b1111 ^ (4'b0001 << ((t_cnt / SD) % 4));
            check("col", COL, ec);
            if (i == 0) begin
                if (have_prev) begin
                    model_step(prev_mask);
                    check("key_event", key_event, m_ev);
                    check("key_code", key_code, m_code);
                    check("entry", entry, m_entry);
                    check("digits", digits, m_digits);
                    check("number", number, m_number);
                    check("number_valid", number_valid, m_nv);
                    if (number_valid) begin
                        if (exp_q.size() == 0) check("nv_unexpected", 1, 0);
                        else check("number_q", number, exp_q.pop_front());
                    end
                end
                if (key_event) ev_seen++;
            end else begin
                extra += int'(key_event) + int'(number_valid);
            end
        end
        check("quiet", extra, 0);
        prev_mask = m;
        have_prev = 1;
    endtask

    task automatic push_key(input int code, input int hold, input int gap);
        for (int i = 0; i < hold; i++) sweep_q.push_back(16'(1) << code);
        for (int i = 0; i < gap; i++) sweep_q.push_back(16'h0000);
    endtask

    task automatic play_all();
        while (sweep_q.size() > 0) play_sweep(sweep_q.pop_front());
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int ev0, code, kind, b0, b1;
        rst_n = 1'b0;
        pressed = '0;
        ev_seen = 0;
        apply_reset();

        // digits then enter: 7 4 2 #
        push_key(8, 5, 5); push_key(4, 5, 5); push_key(1, 5, 5);
        play_all();
        check("entry_742", entry, 742);
        check("digits_3", digits, 3);
        push_key(14, 5, 5);
        play_all();
        check("number_742", number, 742);
        check("entry_clr", entry, 0);

        // overflow: 9 9 9 5
        ev0 = ev_seen;
        push_key(10, 4, 4); push_key(10, 4, 4); push_key(10, 4, 4); push_key(5, 4, 4);
        play_all();
        check("ovf_entry", entry, 999);
        check("ovf_digits", digits, 3);
        check("ovf_events", ev_seen - ev0, 4);
        push_key(14, 4, 4);
        play_all();

        // bounce, multi-key, then a steady 5
        ev0 = ev_seen;
        for (int i = 0; i < 10; i++) sweep_q.push_back((i % 2 == 0) ? 16'h0020 : 16'h0000);
        for (int i = 0; i < 6; i++) sweep_q.push_back(16'h0003);
        push_key(0, 0, 4);
        play_all();
        check("bounce_none", ev_seen - ev0, 0);
        push_key(5, 4, 4);
        play_all();
        check("steady_5", ev_seen - ev0, 1);
        check("code_5", key_code, 5);
        push_key(14, 4, 4);

        // 1 2 3 then '*'
        push_key(0, 4, 4); push_key(1, 4, 4); push_key(2, 4, 4); push_key(12, 4, 4);
        play_all();
`ifdef KEYPAD_BACKSPACE_EN
        check("bs_entry", entry, 12);
        check("bs_digits", digits, 2);
`else
        check("star_entry", entry, 0);
        check("star_digits", digits, 0);
`endif

        // randomized presses, holds, gaps and chords
        while (sweep_q.size() < 200) begin
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                b0 = $urandom_range(0, 15);
                b1 = (b0 + $urandom_range(1, 15)) % 16;
                for (int i = 0; i < int'($urandom_range(1, 4)); i++)
                    sweep_q.push_back((16'(1) << b0) | (16'(1) << b1));
            end else begin
                code = (kind <= 2) ? 14 : int'($urandom_range(0, 15));
                push_key(code, $urandom_range(1, 5), $urandom_range(0, 4));
            end
        end
        push_key(0, 0, 4);
        play_all();

        // reset during the second sweep of a press of 8
        push_key(2, 4, 4);
        play_all();
        pressed = 16'(1) << 9;
        play_sweep(16'(1) << 9);
        repeat (6) begin @(posedge clk); @(negedge clk); end
        apply_reset();
        push_key(9, 4, 4);
        play_all();
        check("post_rst_entry", entry, 8);
        check("post_rst_code", key_code, 9);
        check("exp_q_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
